// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button mode controller.
// Long-press support is enabled by defining BTN_LONG_PRESS_EN.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_LONG_CYC     = 100_000_000;

    // Counter width for a counter that runs 0..n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; btn_level only follows
// the synchronised button after DEBOUNCE_CYC consecutive differing cycles.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int unsigned   DW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q,   level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Any cycle where sync2 agrees with the accepted level restarts the count.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/button_mode_ctrl.sv
// Debounced push button -> short/long press classifier owning the blink-mode bit.
// Define BTN_LONG_PRESS_EN to build the long-press (HELD) path.
module button_mode_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic short,
    output logic btn_level,
    output logic press_pulse,
    output logic long_pulse
);

    if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_param_check
        $error("button_mode_ctrl: DEBOUNCE_CYC and LONG_CYC must be >= 1");
    end

    logic       level;
    btn_state_t state_q, state_d;
    logic       short_q, short_d;
    logic       press_q, press_d;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (level)
    );

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned   HW        = cnt_width(LONG_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

    logic          long_q,   long_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            long_q     <= long_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            short_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            short_q <= short_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        short_d    = short_q;
        press_d    = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        long_d     = 1'b0;
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            // IDLE is only re-entered with level low, so level high here is a rising edge.
            IDLE: begin
                if (level) begin
                    state_d    = PRESSED;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            // Release is tested first so it wins over a coincident hold threshold.
            PRESSED: begin
                if (!level) begin
                    state_d = IDLE;
                    short_d = ~short_q;
                    press_d = 1'b1;
                end
`ifdef BTN_LONG_PRESS_EN
                else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    short_d = 1'b0;
                    long_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
`endif
            end
            HELD: begin
                if (!level) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign short       = short_q;
    assign btn_level   = level;
    assign press_pulse = press_q;

endmodule
